dsp_mac_sequencer: RTL

- Controller that sequences one DSP48A1 slice as a streaming multiply-accumulate engine. Target slice configuration: A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, CARRYINSEL="OPMODE5", B_INPUT="DIRECT".
- Accepts a dot-product job of length len. Takes operand pairs over a valid/ready stream and drives the slice's A, B, OPMODE and clock-enables so that bubbles are tracked through the pipeline.
- Captures the final P into a held result with a valid/ready handshake.
- Sits between the operand source (FIR/matrix front-end) and the slice; it owns all slice control pins.

---
 rtl/dsp_mac_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dsp_mac_sequencer.sv
// Streaming multiply-accumulate controller for one DSP48A1 slice.
// Each accepted operand pair carries a tag through a delay pipe that lines up with the slice's M, OPMODE and P registers.
module dsp_mac_sequencer #(
  parameter int LEN_W      = 16,
  parameter int PIPE_DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_cea,
  output logic             dsp_ceb,
  output logic             dsp_cem,
  output logic             dsp_ceopmode,
  output logic             dsp_cep,
  input  logic [47:0]      dsp_p,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data
);

  localparam logic [7:0] OPM_IDLE = 8'h00;
  localparam logic [7:0] OPM_LOAD = 8'h01;  // X=M, Z=0: first product restarts the sum
  localparam logic [7:0] OPM_ACC  = 8'h09;  // X=M, Z=P

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_CAPTURE,
    S_DONE
  } state_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  state_t                state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [47:0]           res_q, res_d;
  tag_t [PIPE_DEPTH-1:0] pipe_q;
  tag_t [PIPE_DEPTH:0]   stage;
  tag_t                  push;
  logic                  accept;
  logic                  last_pair;
  logic                  last_cep;

  assign accept    = in_valid & in_ready;
  assign last_pair = (cnt_q == len_q - LEN_W'(1));

  always_comb begin
    push.valid = accept;
    push.first = accept & (cnt_q == '0);
    push.last  = accept & last_pair;
  end

  // stage[k] is the tag pushed k cycles ago; stage[0] is this cycle's push.
  assign stage    = {pipe_q, push};
  assign last_cep = stage[PIPE_DEPTH].valid & stage[PIPE_DEPTH].last;

  // NOTE: sequential state is updated with <= so every register samples pre-edge values; combinational blocks use =.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = (len != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        if (accept && last_pair) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (last_cep) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy         = (state_q != S_IDLE);
    in_ready     = (state_q == S_RUN);
    res_valid    = (state_q == S_DONE);
    dsp_cea      = accept;
    dsp_ceb      = accept;
    dsp_cem      = busy;
    dsp_ceopmode = busy;
    dsp_cep      = stage[PIPE_DEPTH].valid;
    dsp_opmode   = OPM_IDLE;
    if (stage[PIPE_DEPTH-1].valid) begin
      dsp_opmode = stage[PIPE_DEPTH-1].first ? OPM_LOAD : OPM_ACC;
    end
  end

  assign dsp_a    = in_a;
  assign dsp_b    = in_b;
  assign res_data = res_q;

  always_comb begin
    len_d = len_q;
    cnt_d = cnt_q;
    res_d = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d = len;
          cnt_d = '0;
          if (len == '0) res_d = '0;
        end
      end
      S_RUN: begin
        if (accept) cnt_d = cnt_q + LEN_W'(1);
      end
      S_CAPTURE: begin
        res_d = dsp_p;
      end
      default: begin
      end
    endcase
  end

  // NOTE: the tag pipe is reset, unlike a data store, because a stale valid bit would fire CEP into the next job.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      len_q  <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
      pipe_q <= '0;
    end else begin
      len_q  <= len_d;
      cnt_q  <= cnt_d;
      res_q  <= res_d;
      pipe_q <= stage[PIPE_DEPTH-1:0];
    end
  end

endmodule
